md5_block_engine: RTL and testbench

Iterative MD5 compression engine. It accepts one 512-bit message block as sixteen 32-bit words over a valid/ready stream and runs the 64 MD5 steps at one step per clock, using a combinational step datapath. It then folds the result into the chaining state and presents the 128-bit digest on a valid/ready output. It sits between the host-side message padder and the digest consumer, and feeds the existing per-round step functions their a, b, c, d, m, s and t operands.

---
 rtl/md5_block_engine_pkg.sv | 54 +++++
 rtl/md5_block_engine_step.sv | 34 +++
 rtl/md5_block_engine.sv | 118 +++++++++++
 tb/tb_md5_block_engine.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_block_engine_pkg.sv
// Shared MD5 definitions: FSM states, initial chaining value, round constants,
// per-step rotate amounts and message word index.
package md5_block_engine_pkg;

   typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_ADD, ST_DONE} state_t;

   localparam logic [31:0] IV_A = 32'h67452301;
   localparam logic [31:0] IV_B = 32'hefcdab89;
   localparam logic [31:0] IV_C = 32'h98badcfe;
   localparam logic [31:0] IV_D = 32'h10325476;

   localparam logic [31:0] K_TAB [64] = '{
      32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
      32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
      32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
      32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
      32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
      32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
      32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
      32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
      32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
      32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
      32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
      32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
      32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
      32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
   };

   // Rotate amounts repeat every four steps within a round: index is {round, step[1:0]}.
   localparam logic [4:0] S_TAB [16] = '{
      5'd7, 5'd12, 5'd17, 5'd22,
      5'd5, 5'd9,  5'd14, 5'd20,
      5'd4, 5'd11, 5'd16, 5'd23,
      5'd6, 5'd10, 5'd15, 5'd21
   };

   function automatic logic [3:0] msg_idx(input logic [5:0] i);
      logic [3:0] j;
      j = i[3:0];
      case (i[5:4])
         2'd0:    msg_idx = j;
         2'd1:    msg_idx = j * 4'd5 + 4'd1;
         2'd2:    msg_idx = j * 4'd3 + 4'd5;
         default: msg_idx = j * 4'd7;
      endcase
   endfunction

   function automatic logic [4:0] shift_amt(input logic [5:0] i);
      return S_TAB[{i[5:4], i[1:0]}];
   endfunction

endpackage

// File: rtl/md5_block_engine_step.sv
// One combinational MD5 step: returns the new b word from a..d, message word,
// round constant, rotate amount and round select.
module md5_step (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c,
   input  logic [31:0] d,
   input  logic [31:0] m,
   input  logic [31:0] t,
   input  logic [4:0]  s,
   input  logic [1:0]  rnd,
   output logic [31:0] new_b
);

   logic [31:0] f;
   logic [31:0] sum;
   logic [5:0]  rs;

   always_comb begin
      // NOTE: f gets a default before the case so no path leaves it unassigned (no latch).
      f = b ^ c ^ d;
      case (rnd)
         2'd0:    f = (b & c) | (~b & d);
         2'd1:    f = (b & d) | (c & ~d);
         2'd2:    f = b ^ c ^ d;
         default: f = c ^ (b | ~d);
      endcase
   end

   assign sum   = a + f + m + t;
   assign rs    = 6'd32 - {1'b0, s};
   assign new_b = b + ((sum << s) | (sum >> rs));

endmodule

// File: rtl/md5_block_engine.sv
// Iterative MD5 block engine: loads sixteen words, runs 64 steps at one per
// clock, folds the result into the chaining state and offers the digest.
module md5_block_engine
   import md5_block_engine_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_word,
   input  logic         in_first,
   output logic         dig_valid,
   input  logic         dig_ready,
   output logic [127:0] digest,
   output logic         busy
);

   state_t      state;
   logic [3:0]  wcnt;
   logic [5:0]  step;
   logic [31:0] msg [16];
   logic [31:0] a, b, c, d;
   logic [31:0] h_a, h_b, h_c, h_d;
   logic [31:0] m_sel, k_sel, new_b;
   logic [4:0]  s_sel;

   assign m_sel  = msg[msg_idx(step)];
   assign k_sel  = K_TAB[step];
   assign s_sel  = shift_amt(step);
   assign digest = {h_a, h_b, h_c, h_d};

   md5_step u_step (
      .a     (a),
      .b     (b),
      .c     (c),
      .d     (d),
      .m     (m_sel),
      .t     (k_sel),
      .s     (s_sel),
      .rnd   (step[5:4]),
      .new_b (new_b)
   );

   // NOTE: non-blocking assignments throughout; the a..d rotation relies on every
   // register seeing pre-edge values. The word buffer is reset as well, so an
   // aborted block cannot leave stale words behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_LOAD;
         wcnt      <= '0;
         step      <= '0;
         for (int k = 0; k < 16; k++) msg[k] <= '0;
         a         <= '0;
         b         <= '0;
         c         <= '0;
         d         <= '0;
         h_a       <= IV_A;
         h_b       <= IV_B;
         h_c       <= IV_C;
         h_d       <= IV_D;
         in_ready  <= 1'b1;
         dig_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (in_valid && in_ready) begin
                  msg[wcnt] <= in_word;
                  wcnt      <= wcnt + 4'd1;
                  if (wcnt == 4'd0 && in_first) begin
                     h_a <= IV_A;
                     h_b <= IV_B;
                     h_c <= IV_C;
                     h_d <= IV_D;
                  end
                  // H already holds IV here if this block started a new message.
                  if (wcnt == 4'd15) begin
                     a        <= h_a;
                     b        <= h_b;
                     c        <= h_c;
                     d        <= h_d;
                     step     <= '0;
                     state    <= ST_RUN;
                     in_ready <= 1'b0;
                     busy     <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               a    <= d;
               b    <= new_b;
               c    <= b;
               d    <= c;
               step <= step + 6'd1;
               if (step == 6'd63) state <= ST_ADD;
            end
            ST_ADD: begin
               h_a       <= h_a + a;
               h_b       <= h_b + b;
               h_c       <= h_c + c;
               h_d       <= h_d + d;
               state     <= ST_DONE;
               dig_valid <= 1'b1;
            end
            ST_DONE: begin
               if (dig_ready) begin
                  state     <= ST_LOAD;
                  dig_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_md5_block_engine.sv
// Scoreboard bench for md5_block_engine: expected digests are queued as blocks
// are sent and compared when the engine presents them.
module tb_md5_block_engine;

   typedef logic [31:0] blk_t [16];

   localparam logic [127:0] IV        = 128'h67452301_efcdab89_98badcfe_10325476;
   localparam logic [127:0] DIG_EMPTY = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec;
   localparam logic [127:0] DIG_ABC   = 128'h98500190_b04fd23c_7d3f96d6_727fe128;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_first = 1'b0;
   logic         dig_ready = 1'b0;
   logic [31:0]  in_word = '0;
   logic         in_ready, dig_valid, busy;
   logic [127:0] digest;

   int           errors = 0;
   int           checks = 0;
   int           last_edges;
   logic [127:0] exp_q [$];
   logic [31:0]  kt [64];

   always #5 clk = ~clk;

   md5_block_engine dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_word   (in_word),
      .in_first  (in_first),
      .dig_valid (dig_valid),
      .dig_ready (dig_ready),
      .digest    (digest),
      .busy      (busy)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Reference model built from the algorithm description; K derived from sin().
   function automatic int sh(input int i);
      int r;
      r = i % 4;
      case (i / 16)
         0:       return (r == 0) ? 7 : (r == 1) ? 12 : (r == 2) ? 17 : 22;
         1:       return (r == 0) ? 5 : (r == 1) ? 9  : (r == 2) ? 14 : 20;
         2:       return (r == 0) ? 4 : (r == 1) ? 11 : (r == 2) ? 16 : 23;
         default: return (r == 0) ? 6 : (r == 1) ? 10 : (r == 2) ? 15 : 21;
      endcase
   endfunction

   function automatic logic [127:0] md5_model(input logic [127:0] hin, input blk_t w);
      logic [31:0] va, vb, vc, vd, f, tmp, nb;
      int g, s;
      va = hin[127:96]; vb = hin[95:64]; vc = hin[63:32]; vd = hin[31:0];
      for (int i = 0; i < 64; i++) begin
         if (i < 16)      begin f = (vb & vc) | (~vb & vd); g = i; end
         else if (i < 32) begin f = (vb & vd) | (vc & ~vd); g = (5 * i + 1) % 16; end
         else if (i < 48) begin f = vb ^ vc ^ vd;           g = (3 * i + 5) % 16; end
         else             begin f = vc ^ (vb | ~vd);        g = (7 * i) % 16; end
         s   = sh(i);
         tmp = va + f + kt[i] + w[g];
         nb  = vb + ((tmp << s) | (tmp >> (32 - s)));
         va  = vd; vd = vc; vc = vb; vb = nb;
      end
      return {hin[127:96] + va, hin[95:64] + vb, hin[63:32] + vc, hin[31:0] + vd};
   endfunction

   task automatic send_block(input blk_t w, input logic first, input int gap_max,
                             input logic expect_dig, input logic [127:0] exp);
      int budget;
      int gap;
      if (expect_dig) exp_q.push_back(exp);
      for (int k = 0; k < 16; k++) begin
         if (gap_max > 0) begin
            gap = $urandom_range(gap_max, 0);
            in_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
         end
         in_valid = 1'b1;
         in_word  = w[k];
         in_first = (k == 0) ? first : ~first;
         budget   = 0;
         while (!in_ready && budget < 300) begin @(posedge clk); #1; budget++; end
         if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL load_timeout word=%0d in_ready=%b required 1", k, in_ready);
            in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_first = 1'b0;
   endtask

   // Waits for the digest, compares it with the scoreboard head and hands it off.
   task automatic collect_digest(input string name);
      logic [127:0] exp;
      int n;
      n = 0;
      while (!dig_valid && n < 300) begin @(posedge clk); #1; n++; end
      last_edges = n;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard empty, got digest=%h", name, digest);
      end else begin
         exp = exp_q.pop_front();
         if (!dig_valid) begin
            errors++;
            $display("FAIL %s dig_valid timeout, got 0 required 1", name);
         end else if (digest !== exp) begin
            errors++;
            $display("FAIL %s digest got=%h required=%h", name, digest, exp);
         end
      end
      dig_ready = 1'b1;
      @(posedge clk); #1;
      dig_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || dig_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s after handoff in_ready=%b dig_valid=%b required 1/0",
                  name, in_ready, dig_valid);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || dig_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags in_ready=%b dig_valid=%b busy=%b required 1/0/0",
                  in_ready, dig_valid, busy);
      end
      checks++;
      if (digest !== IV) begin
         errors++;
         $display("FAIL reset_digest got=%h required=%h", digest, IV);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_empty();
      blk_t w;
      w = '{0: 32'h00000080, default: 32'h0};
      send_block(w, 1'b1, 0, 1'b1, DIG_EMPTY);
      collect_digest("empty");
      // Edge count n after the word-15 edge means dig_valid shows in cycle T+n+1.
      checks++;
      if (last_edges + 1 !== 66) begin
         errors++;
         $display("FAIL empty_latency got cycle T+%0d required T+66", last_edges + 1);
      end
   endtask

   task automatic test_abc_gaps();
      blk_t w;
      w = '{0: 32'h80636261, 14: 32'h00000018, default: 32'h0};
      send_block(w, 1'b1, 3, 1'b1, DIG_ABC);
      collect_digest("abc_gaps");
   endtask

   task automatic test_back_to_back();
      blk_t e, w;
      e = '{0: 32'h00000080, default: 32'h0};
      w = '{0: 32'h80636261, 14: 32'h00000018, default: 32'h0};
      send_block(e, 1'b1, 0, 1'b1, DIG_EMPTY);
      collect_digest("b2b_empty");
      send_block(w, 1'b1, 0, 1'b1, DIG_ABC);
      collect_digest("b2b_abc");
   endtask

   task automatic test_backpressure();
      blk_t e, w;
      int n;
      e = '{0: 32'h00000080, default: 32'h0};
      w = '{0: 32'h80636261, 14: 32'h00000018, default: 32'h0};
      send_block(w, 1'b1, 0, 1'b1, DIG_ABC);
      n = 0;
      while (!dig_valid && n < 300) begin @(posedge clk); #1; n++; end
      in_valid = 1'b1;
      in_word  = 32'hdeadbeef;
      in_first = 1'b1;
      for (int k = 0; k < 20; k++) begin
         checks++;
         if (dig_valid !== 1'b1 || digest !== DIG_ABC || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hold cyc=%0d dig_valid=%b in_ready=%b busy=%b digest=%h required 1/0/1 %h",
                     k, dig_valid, in_ready, busy, digest, DIG_ABC);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_first = 1'b0;
      collect_digest("backpressure_abc");
      send_block(e, 1'b1, 0, 1'b1, DIG_EMPTY);
      collect_digest("after_hold_empty");
   endtask

   task automatic test_chaining();
      blk_t b1, b2;
      logic [127:0] h1;
      for (int k = 0; k < 16; k++) begin
         b1[k] = $urandom;
         b2[k] = $urandom;
      end
      h1 = md5_model(IV, b1);
      send_block(b1, 1'b1, 1, 1'b1, h1);
      collect_digest("chain_blk1");
      send_block(b2, 1'b0, 1, 1'b1, md5_model(h1, b2));
      collect_digest("chain_blk2");
      send_block(b1, 1'b1, 0, 1'b1, h1);
      collect_digest("restart_blk1");
      send_block(b2, 1'b1, 0, 1'b1, md5_model(IV, b2));
      collect_digest("restart_blk2");
   endtask

   task automatic test_reset_mid_run();
      blk_t r, w;
      for (int k = 0; k < 16; k++) r[k] = $urandom;
      w = '{0: 32'h80636261, 14: 32'h00000018, default: 32'h0};
      send_block(r, 1'b1, 0, 1'b0, '0);
      repeat (30) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || dig_valid !== 1'b0 || busy !== 1'b0 || digest !== IV) begin
         errors++;
         $display("FAIL midrun_reset in_ready=%b dig_valid=%b busy=%b digest=%h required 1/0/0 %h",
                  in_ready, dig_valid, busy, digest, IV);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (70) @(posedge clk);
      #1;
      checks++;
      if (dig_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL aborted_block dig_valid=%b in_ready=%b required 0/1", dig_valid, in_ready);
      end
      send_block(w, 1'b1, 0, 1'b1, DIG_ABC);
      collect_digest("abc_after_reset");
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         real x;
         x = $sin(real'(i + 1));
         if (x < 0.0) x = -x;
         kt[i] = 32'(longint'($floor(x * 4294967296.0)));
      end
      test_reset();
      test_empty();
      test_abc_gaps();
      test_back_to_back();
      test_backpressure();
      test_chaining();
      test_reset_mid_run();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got=%0d required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
